// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave cook sequencer: digit widths, FSM
// state encodings, default beep length and the mm:ss BCD decrement helper.
package microwave_pkg;

    localparam int unsigned DIGIT_W        = 4;
    localparam int unsigned NUM_DIGITS     = 4;
    localparam int unsigned TIME_W         = DIGIT_W * NUM_DIGITS;
    localparam int unsigned STATE_W        = 3;
    localparam int unsigned BEEP_TICKS_DEF = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_COOK  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } cook_state_t;

    // One-second decrement of {min_tens, min_ones, sec_tens, sec_ones} with
    // BCD borrow; sec_tens wraps to 5, the other low digits wrap to 9.
    function automatic logic [TIME_W-1:0] bcd_dec(input logic [TIME_W-1:0] t);
        logic [TIME_W-1:0] r;
        r = t;
        if (t[3:0] != DIGIT_W'(0)) begin
            r[3:0] = t[3:0] - DIGIT_W'(1);
        end else begin
            r[3:0] = DIGIT_W'(9);
            if (t[7:4] != DIGIT_W'(0)) begin
                r[7:4] = t[7:4] - DIGIT_W'(1);
            end else begin
                r[7:4] = DIGIT_W'(5);
                if (t[11:8] != DIGIT_W'(0)) begin
                    r[11:8] = t[11:8] - DIGIT_W'(1);
                end else begin
                    r[11:8]  = DIGIT_W'(9);
                    r[15:12] = t[15:12] - DIGIT_W'(1);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mmss_bcd_counter.sv
// mm:ss BCD time register: keypad digit shift-in, one-second decrement, clear.
// Ports: clock/clearn; clr, shift (+digit), dec commands (clr > shift > dec);
// time_bcd registered value; zero_c = time is 0000; last_c = next dec hits 0000.
module mmss_bcd_counter
    import microwave_pkg::*;
(
    input  logic               clock,
    input  logic               clearn,
    input  logic               clr,
    input  logic               shift,
    input  logic [DIGIT_W-1:0] digit,
    input  logic               dec,
    output logic [TIME_W-1:0]  time_bcd,
    output logic               zero_c,
    output logic               last_c
);

    // Time register update
    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            time_bcd <= '0;
        end else if (clr) begin
            time_bcd <= '0;
        end else if (shift) begin
            time_bcd <= {time_bcd[TIME_W-DIGIT_W-1:0], digit};
        end else if (dec) begin
            time_bcd <= bcd_dec(time_bcd);
        end
    end

    // Only 00:01 can decrement to 00:00
    assign zero_c = (time_bcd == TIME_W'(0));
    assign last_c = (time_bcd == TIME_W'(1));

endmodule

// File: rtl/cook_sequencer.sv
// Microwave cook sequencer: keypad entry, countdown cooking, pause, done beep.
// Ports: clock/clearn; D/loadn keypad digit; pgt_1Hz tick level; startn/stopn
// buttons; door_closed; outputs enablen (keypad enable, low active), mag_on,
// done, time_bcd {mm,ss} BCD and state (debug).
module cook_sequencer
    import microwave_pkg::*;
#(
    parameter int unsigned BEEP_TICKS = BEEP_TICKS_DEF
) (
    input  logic               clock,
    input  logic               clearn,
    input  logic [DIGIT_W-1:0] D,
    input  logic               loadn,
    input  logic               pgt_1Hz,
    input  logic               startn,
    input  logic               stopn,
    input  logic               door_closed,
    output logic               enablen,
    output logic               mag_on,
    output logic               done,
    output logic [TIME_W-1:0]  time_bcd,
    output logic [STATE_W-1:0] state
);

    localparam int unsigned BEEP_W = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS) : 1;

    logic loadn_q, startn_q, stopn_q, tick_q;
    logic key_c, start_c, stop_c, tick_c;
    cook_state_t state_q, state_nx;
    logic [BEEP_W-1:0] beep_q, beep_nx;
    logic cnt_clr, cnt_shift, cnt_dec;
    logic zero_c, last_c;

    // Previous samples for edge detection; reset to inactive level
    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            loadn_q  <= 1'b1;
            startn_q <= 1'b1;
            stopn_q  <= 1'b1;
            tick_q   <= 1'b1;
        end else begin
            loadn_q  <= loadn;
            startn_q <= startn;
            stopn_q  <= stopn;
            tick_q   <= pgt_1Hz;
        end
    end

    assign key_c   = loadn_q & ~loadn & (D <= DIGIT_W'(9));
    assign start_c = startn_q & ~startn;
    assign stop_c  = stopn_q & ~stopn;
    assign tick_c  = ~tick_q & pgt_1Hz;

    mmss_bcd_counter u_counter (
        .clock    (clock),
        .clearn   (clearn),
        .clr      (cnt_clr),
        .shift    (cnt_shift),
        .digit    (D),
        .dec      (cnt_dec),
        .time_bcd (time_bcd),
        .zero_c   (zero_c),
        .last_c   (last_c)
    );

    // Next-state and counter commands; stop outranks start everywhere
    always_comb begin
        state_nx  = state_q;
        beep_nx   = beep_q;
        cnt_clr   = 1'b0;
        cnt_shift = 1'b0;
        cnt_dec   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (stop_c) begin
                    cnt_clr = 1'b1;
                end else if (key_c) begin
                    cnt_shift = 1'b1;
                    state_nx  = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                if (stop_c) begin
                    cnt_clr  = 1'b1;
                    state_nx = ST_IDLE;
                end else if (start_c && door_closed && !zero_c) begin
                    state_nx = ST_COOK;
                end else if (key_c) begin
                    cnt_shift = 1'b1;
                end
            end
            ST_COOK: begin
                if (stop_c || !door_closed) begin
                    state_nx = ST_PAUSE;
                end else if (tick_c) begin
                    cnt_dec = 1'b1;
                    if (last_c) begin
                        state_nx = ST_DONE;
                        beep_nx  = '0;
                    end
                end
            end
            ST_PAUSE: begin
                if (stop_c) begin
                    cnt_clr  = 1'b1;
                    state_nx = ST_IDLE;
                end else if (start_c && door_closed) begin
                    state_nx = ST_COOK;
                end
            end
            ST_DONE: begin
                if (stop_c) begin
                    cnt_clr  = 1'b1;
                    beep_nx  = '0;
                    state_nx = ST_IDLE;
                end else if (tick_c) begin
                    if (beep_q == BEEP_W'(BEEP_TICKS - 1)) begin
                        beep_nx  = '0;
                        state_nx = ST_IDLE;
                    end else begin
                        beep_nx = beep_q + BEEP_W'(1);
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
                beep_nx  = '0;
            end
        endcase
    end

    // State, beep counter and Moore outputs decoded from the next state
    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            state_q <= ST_IDLE;
            beep_q  <= '0;
            mag_on  <= 1'b0;
            done    <= 1'b0;
            enablen <= 1'b0;
        end else begin
            state_q <= state_nx;
            beep_q  <= beep_nx;
            mag_on  <= (state_nx == ST_COOK);
            done    <= (state_nx == ST_DONE);
            enablen <= !((state_nx == ST_IDLE) || (state_nx == ST_ENTRY));
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_cook_sequencer.sv
// Self-checking bench for cook_sequencer: directed scenarios, expected
// state/time pushed to a scoreboard queue per step and checked after it.
module tb_cook_sequencer;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ENTRY = 3'd1;
    localparam logic [2:0] S_COOK  = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic        clock = 1'b0;
    logic        clearn = 1'b0;
    logic [3:0]  D = 4'd0;
    logic        loadn = 1'b1;
    logic        pgt_1Hz = 1'b0;
    logic        startn = 1'b1;
    logic        stopn = 1'b1;
    logic        door_closed = 1'b1;
    logic        enablen, mag_on, done;
    logic [15:0] time_bcd;
    logic [2:0]  state;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [2:0]  st;
        logic [15:0] t;
    } exp_t;
    exp_t sbq[$];

    cook_sequencer #(.BEEP_TICKS(3)) dut (
        .clock       (clock),
        .clearn      (clearn),
        .D           (D),
        .loadn       (loadn),
        .pgt_1Hz     (pgt_1Hz),
        .startn      (startn),
        .stopn       (stopn),
        .door_closed (door_closed),
        .enablen     (enablen),
        .mag_on      (mag_on),
        .done        (done),
        .time_bcd    (time_bcd),
        .state       (state)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Compare all outputs against the oldest expectation; outputs follow state
    task automatic sb_compare();
        exp_t e;
        if (sbq.size() == 0) begin
            check_eq("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            check_eq({e.tag, ".state"}, 32'(state), 32'(e.st));
            check_eq({e.tag, ".time"}, 32'(time_bcd), 32'(e.t));
            check_eq({e.tag, ".mag_on"}, 32'(mag_on), 32'(e.st == S_COOK));
            check_eq({e.tag, ".done"}, 32'(done), 32'(e.st == S_DONE));
            check_eq({e.tag, ".enablen"}, 32'(enablen),
                     32'(!((e.st == S_IDLE) || (e.st == S_ENTRY))));
        end
    endtask

    // One event cycle: assert chosen pulses at negedge, release a cycle later
    task automatic step(input string tag, input logic k, input logic [3:0] d,
                        input logic st, input logic sp, input logic tk, input logic dc,
                        input logic [2:0] exp_st, input logic [15:0] exp_t);
        exp_t e;
        e.tag = tag; e.st = exp_st; e.t = exp_t;
        sbq.push_back(e);
        @(negedge clock);
        D = d;
        loadn = ~k;
        startn = ~st;
        stopn = ~sp;
        pgt_1Hz = tk;
        door_closed = dc;
        @(negedge clock);
        loadn = 1'b1;
        startn = 1'b1;
        stopn = 1'b1;
        pgt_1Hz = 1'b0;
        sb_compare();
    endtask

    task automatic key(input string tag, input logic [3:0] d, input logic [2:0] s, input logic [15:0] t);
        step(tag, 1'b1, d, 1'b0, 1'b0, 1'b0, door_closed, s, t);
    endtask
    task automatic start(input string tag, input logic [2:0] s, input logic [15:0] t);
        step(tag, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, door_closed, s, t);
    endtask
    task automatic stop(input string tag, input logic [2:0] s, input logic [15:0] t);
        step(tag, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, door_closed, s, t);
    endtask
    task automatic tick(input string tag, input logic [2:0] s, input logic [15:0] t);
        step(tag, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, door_closed, s, t);
    endtask

    initial begin
        // Reset state, checked while clearn is still low
        #2;
        begin
            exp_t e;
            e.tag = "reset"; e.st = S_IDLE; e.t = 16'h0000;
            sbq.push_back(e);
            sb_compare();
        end
        @(negedge clock);
        clearn = 1'b1;

        // Keys 1,2,3 then cook and tick
        key("k1", 4'd1, S_ENTRY, 16'h0001);
        key("k2", 4'd2, S_ENTRY, 16'h0012);
        key("k3", 4'd3, S_ENTRY, 16'h0123);
        start("start123", S_COOK, 16'h0123);
        tick("tick123", S_COOK, 16'h0122);
        stop("stop_cook", S_PAUSE, 16'h0122);
        stop("stop_pause", S_IDLE, 16'h0000);

        // Minute borrow and sec_tens above 5
        key("k100a", 4'd1, S_ENTRY, 16'h0001);
        key("k100b", 4'd0, S_ENTRY, 16'h0010);
        key("k100c", 4'd0, S_ENTRY, 16'h0100);
        start("start100", S_COOK, 16'h0100);
        tick("tick100", S_COOK, 16'h0059);
        stop("stop100a", S_PAUSE, 16'h0059);
        stop("stop100b", S_IDLE, 16'h0000);
        key("k90a", 4'd9, S_ENTRY, 16'h0009);
        key("k90b", 4'd0, S_ENTRY, 16'h0090);
        start("start90", S_COOK, 16'h0090);
        tick("tick90", S_COOK, 16'h0089);
        stop("stop90a", S_PAUSE, 16'h0089);
        stop("stop90b", S_IDLE, 16'h0000);

        // Countdown to DONE, then beep length
        key("k2s", 4'd2, S_ENTRY, 16'h0002);
        start("start2s", S_COOK, 16'h0002);
        tick("tick2s_a", S_COOK, 16'h0001);
        tick("tick2s_b", S_DONE, 16'h0000);
        tick("beep1", S_DONE, 16'h0000);
        tick("beep2", S_DONE, 16'h0000);
        tick("beep3", S_IDLE, 16'h0000);

        // Door opened in the same cycle as a tick
        key("k45a", 4'd4, S_ENTRY, 16'h0004);
        key("k45b", 4'd5, S_ENTRY, 16'h0045);
        start("start45", S_COOK, 16'h0045);
        step("door_tick", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, S_PAUSE, 16'h0045);
        tick("pause_tick", S_PAUSE, 16'h0045);
        start("pause_start_open", S_PAUSE, 16'h0045);
        step("resume", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, S_COOK, 16'h0045);
        stop("stop45a", S_PAUSE, 16'h0045);
        stop("stop45b", S_IDLE, 16'h0000);

        // Five keys, invalid digit, start with zero time
        key("k5_1", 4'd1, S_ENTRY, 16'h0001);
        key("k5_2", 4'd2, S_ENTRY, 16'h0012);
        key("k5_3", 4'd3, S_ENTRY, 16'h0123);
        key("k5_4", 4'd4, S_ENTRY, 16'h1234);
        key("k5_5", 4'd5, S_ENTRY, 16'h2345);
        key("k12", 4'd12, S_ENTRY, 16'h2345);
        stop("stop_entry", S_IDLE, 16'h0000);
        start("start_zero", S_IDLE, 16'h0000);
        key("k12_idle", 4'd12, S_IDLE, 16'h0000);

        // Door open blocks start; start+stop together clears
        key("k7", 4'd7, S_ENTRY, 16'h0007);
        step("start_door_open", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, S_ENTRY, 16'h0007);
        step("start_stop", 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, S_IDLE, 16'h0000);

        // Stop in DONE returns immediately
        key("k1d", 4'd1, S_ENTRY, 16'h0001);
        start("start1d", S_COOK, 16'h0001);
        tick("tick1d", S_DONE, 16'h0000);
        stop("stop_done", S_IDLE, 16'h0000);

        // Asynchronous reset in the middle of cooking
        key("k3r", 4'd3, S_ENTRY, 16'h0003);
        start("start3r", S_COOK, 16'h0003);
        #3;
        clearn = 1'b0;
        #1;
        check_eq("async_rst.mag_on", 32'(mag_on), 32'd0);
        check_eq("async_rst.state", 32'(state), 32'(S_IDLE));
        check_eq("async_rst.time", 32'(time_bcd), 32'h0000);
        check_eq("async_rst.enablen", 32'(enablen), 32'd0);
        @(negedge clock);
        clearn = 1'b1;
        key("after_rst", 4'd6, S_ENTRY, 16'h0006);

        check_eq("sb_drained", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cook_sequencer.md
COOK_SEQUENCER -- requirements
Module: cook_sequencer

Interface
REQ-001 The block SHALL have one parameter, BEEP_TICKS, default 3, giving the number of 1 Hz ticks DONE is held before returning to IDLE.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clock  in  1  sole clock, rising edge.
- clearn  in  1  reset, asynchronous, active-low.
- D  in  4  BCD key digit from keypad controller.
- loadn  in  1  active-low digit-valid from keypad controller.
- pgt_1Hz  in  1  1 Hz tick level, synchronous to clock.
- startn  in  1  start button, active-low, synchronous.
- stopn  in  1  stop/clear button, active-low, synchronous.
- door_closed  in  1  1 = door closed.
- enablen  out  1  keypad enable to keypad controller, active-low.
- mag_on  out  1  magnetron drive.
- done  out  1  end-of-cook beep.
- time_bcd  out  16  {min_tens, min_ones, sec_tens, sec_ones}, BCD.
- state  out  3  current FSM state, for debug.

Function
REQ-003 Edge events SHALL be single-cycle: key = loadn high->low; start = startn high->low; stop = stopn high->low; tick = pgt_1Hz low->high. Each is detected against a registered previous sample.
REQ-004 FSM states SHALL be IDLE, ENTRY, COOK, PAUSE and DONE. Every output is registered or decoded from state only (Moore). Outputs change on the clock edge that follows the event cycle.
REQ-005 A key event with D<=9 in IDLE or ENTRY SHALL shift time_bcd left one digit and insert D as sec_ones; the old min_tens is discarded. IDLE then goes to ENTRY. A key with D>9, or a key in any other state, SHALL be ignored.
REQ-006 ENTRY: stop SHALL clear time_bcd to 0000 and go to IDLE. Start SHALL go to COOK only if door_closed=1 and time_bcd!=0000; otherwise start is ignored.
REQ-007 COOK: each tick SHALL decrement time_bcd by one second with BCD borrow. sec_ones 0->9 borrows. sec_tens 0->5 borrows. min_ones 0->9 borrows. min_tens decrements. An entered sec_tens of 6-9 counts down normally (0090 -> 0089).
REQ-008 COOK: if a tick brings time_bcd to 0000, the block SHALL go to DONE on that same edge.
REQ-009 COOK: door_closed=0 or stop SHALL go to PAUSE with no decrement, even if a tick occurs in the same cycle.
REQ-010 PAUSE: start with door_closed=1 SHALL return to COOK with time_bcd retained. Stop SHALL clear time_bcd and go to IDLE. Ticks SHALL be ignored.
REQ-011 DONE: done=1. The block SHALL count ticks and return to IDLE with done=0 after BEEP_TICKS ticks. Stop SHALL go to IDLE immediately.
REQ-012 Start and stop in the same cycle: stop SHALL win in every state.
REQ-013 mag_on SHALL be 1 only in COOK. enablen SHALL be 0 only in IDLE and ENTRY.

Reset
REQ-014 clearn=0 SHALL asynchronously force the following: state=IDLE, time_bcd=0000, mag_on=0, done=0, enablen=0, beep counter=0, and all edge-detect registers to their inactive level (loadn=1, startn=1, stopn=1, pgt_1Hz=1). Reset asserted mid-COOK SHALL drop mag_on without waiting for a clock edge.

Structure
REQ-015 State encodings, BEEP_TICKS default and the BCD digit width SHALL live in shared package microwave_pkg.
REQ-016 The digit shift/load, BCD decrement and zero flag SHALL be one sub-module, mmss_bcd_counter. The FSM and the edge detectors stay in cook_sequencer.

Verification
REQ-017 The bench SHALL cover these directed scenarios.
- Keys 1,2,3 then start, door closed -> time_bcd=0123, COOK, mag_on=1. One tick -> 0122.
- Load 0100, cook, one tick -> 0059. Load 0090, one tick -> 0089.
- Load 0002, cook, two ticks -> DONE with done=1 and mag_on=0. After 3 more ticks -> IDLE, done=0.
- In COOK at 0045, door_closed=0 in the same cycle as a tick -> PAUSE, time stays 0045. Door closed then start -> COOK. Stop in PAUSE -> IDLE, 0000.
- Five keys 1..5 -> time_bcd=2345. Key D=12 -> unchanged. Start with time 0000 -> stays IDLE.
- Start and stop in the same cycle in ENTRY -> IDLE, 0000. clearn low mid-COOK -> mag_on=0 immediately.
